// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: control codes, sequencer states
// and small datapath helpers.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_zero32(input logic [31:0] value);
        return (value == 32'd0);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; unknown control codes produce 0 with the zero flag set.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [2:0]  ALUCtrl_i,
    output logic [31:0] data_o,
    output logic        Zero_o
);

    // Operation select; all results wrap to 32 bits
    always_comb begin
        data_o = 32'd0;
        case (ALUCtrl_i)
            ALU_AND: data_o = data1_i & data2_i;
            ALU_OR:  data_o = data1_i | data2_i;
            ALU_ADD: data_o = data1_i + data2_i;
            ALU_SUB: data_o = data1_i - data2_i;
            ALU_MUL: data_o = data1_i * data2_i;
            default: data_o = 32'd0;
        endcase
    end

    assign Zero_o = is_zero32(data_o);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU: captures one operation,
// runs it for 1 or MUL_LAT cycles, and returns a tagged, held response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_data1_i,
    input  logic [31:0] req0_data2_i,
    input  logic [2:0]  req0_ctrl_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_data1_i,
    input  logic [31:0] req1_data2_i,
    input  logic [2:0]  req1_ctrl_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        resp_id_o,
    output logic [31:0] resp_data_o,
    output logic        resp_zero_o
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        id_q, id_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_zero_q, resp_zero_d;

    logic        gnt0_s, gnt1_s;
    logic [31:0] alu_data_s;
    logic        alu_zero_s;

    // On a tie the requester that did not win last time is granted
    assign gnt0_s = req0_valid_i & (~req1_valid_i | last_grant_q);
    assign gnt1_s = req1_valid_i & (~req0_valid_i | ~last_grant_q);

    assign req0_ready_o = (state_q == IDLE) & gnt0_s & ~rst_i;
    assign req1_ready_o = (state_q == IDLE) & gnt1_s & ~rst_i;

    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_data_o  = resp_data_q;
    assign resp_zero_o  = resp_zero_q;

    alu_arbiter_alu u_alu (
        .data1_i   (op_a_q),
        .data2_i   (op_b_q),
        .ALUCtrl_i (ctrl_q),
        .data_o    (alu_data_s),
        .Zero_o    (alu_zero_s)
    );

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            ctrl_q       <= 3'b000;
            id_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            ctrl_q       <= ctrl_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_zero_q  <= resp_zero_d;
        end
    end

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt0_s || gnt1_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = EXEC;
                end
            end
            DONE: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, multiply stretch counter and response registers
    always_comb begin
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        ctrl_d       = ctrl_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_zero_d  = resp_zero_q;
        case (state_q)
            IDLE: begin
                if (gnt0_s) begin
                    op_a_d       = req0_data1_i;
                    op_b_d       = req0_data2_i;
                    ctrl_d       = req0_ctrl_i;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    cnt_d        = (req0_ctrl_i == ALU_MUL) ? MUL_CNT : 4'd0;
                end else if (gnt1_s) begin
                    op_a_d       = req1_data1_i;
                    op_b_d       = req1_data2_i;
                    ctrl_d       = req1_ctrl_i;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    cnt_d        = (req1_ctrl_i == ALU_MUL) ? MUL_CNT : 4'd0;
                end else begin
                    cnt_d        = 4'd0;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_data_d  = alu_data_s;
                    resp_zero_d  = alu_zero_s;
                end
            end
            DONE: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model.
module tb_alu_arbiter;

    localparam int MUL_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_d1, req0_d2, req1_d1, req1_d2;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic        resp_valid, resp_ready, resp_id, resp_zero;
    logic [31:0] resp_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic sticky;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_data1_i (req0_d1),
        .req0_data2_i (req0_d2),
        .req0_ctrl_i  (req0_ctrl),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_data1_i (req1_d1),
        .req1_data2_i (req1_d2),
        .req1_ctrl_i  (req1_ctrl),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
        .resp_zero_o  (resp_zero)
    );

    // Reference ALU from the operation table, computed on a 64-bit product/sum
    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        case (c)
            3'b010:  wide = {32'd0, a} + {32'd0, b};
            3'b110:  wide = {32'd0, a} - {32'd0, b};
            3'b001:  wide = {32'd0, a | b};
            3'b000:  wide = {32'd0, a & b};
            3'b111:  wide = {32'd0, a} * {32'd0, b};
            default: wide = 64'd0;
        endcase
        return wide[31:0];
    endfunction

    // Cycles from the accept cycle to the first cycle the response is visible
    function automatic int ref_lat(input logic [2:0] c);
        return (c == 3'b111) ? 1 + MUL_LAT : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    endtask

    // Compare process: model pins, then per-cycle comparison against the model
    initial begin : compare
        logic        busy, last, fresh, ev, er0, er1;
        logic        m_id, m_zero;
        logic [31:0] m_data;
        int          due;
        busy = 1'b0; last = 1'b1; fresh = 1'b1; due = 0;
        m_id = 1'b0; m_zero = 1'b0; m_data = 32'd0;

        check("pin_add",  ref_alu(3'b010, 32'd5, 32'd7), 32'd12);
        check("pin_sub",  ref_alu(3'b110, 32'd9, 32'd9), 32'd0);
        check("pin_wrap", ref_alu(3'b110, 32'd0, 32'd1), 32'hFFFF_FFFF);
        check("pin_or",   ref_alu(3'b001, 32'hF0, 32'h0F), 32'hFF);
        check("pin_mul",  ref_alu(3'b111, 32'h1_0000, 32'h1_0000), 32'd0);
        check("pin_mul2", ref_alu(3'b111, 32'd3, 32'd5), 32'd15);
        check("pin_undef", ref_alu(3'b011, 32'd3, 32'd4), 32'd0);
        check("pin_lat_mul", 32'(ref_lat(3'b111)), 32'd5);
        check("pin_lat_add", 32'(ref_lat(3'b010)), 32'd2);

        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check1("rst_valid", resp_valid, 1'b0);
                check1("rst_ready0", req0_ready, 1'b0);
                check1("rst_ready1", req1_ready, 1'b0);
                check1("rst_id", resp_id, 1'b0);
                check("rst_data", resp_data, 32'd0);
                check1("rst_zero", resp_zero, 1'b0);
                busy = 1'b0; last = 1'b1; fresh = 1'b1;
            end else begin
                ev  = busy && (cyc >= due);
                er0 = !busy && req0_valid && (!req1_valid || last);
                er1 = !busy && req1_valid && (!req0_valid || !last);
                check1("resp_valid", resp_valid, ev);
                check1("req0_ready", req0_ready, er0);
                check1("req1_ready", req1_ready, er1);
                if (ev) begin
                    check1("resp_id", resp_id, m_id);
                    check("resp_data", resp_data, m_data);
                    check1("resp_zero", resp_zero, m_zero);
                    fresh = 1'b0;
                end else if (fresh) begin
                    check("idle_data", resp_data, 32'd0);
                end
                if (ev && resp_ready) begin
                    busy = 1'b0;
                end else if (er0) begin
                    busy = 1'b1; m_id = 1'b0; last = 1'b0;
                    m_data = ref_alu(req0_ctrl, req0_d1, req0_d2);
                    m_zero = (m_data == 32'd0);
                    due = cyc + ref_lat(req0_ctrl);
                end else if (er1) begin
                    busy = 1'b1; m_id = 1'b1; last = 1'b1;
                    m_data = ref_alu(req1_ctrl, req1_d1, req1_d2);
                    m_zero = (m_data == 32'd0);
                    due = cyc + ref_lat(req1_ctrl);
                end
            end
        end
    end

    // Advance n cycles; an accepted request is withdrawn unless sticky is set
    task automatic step(input int n);
        logic a0, a1;
        repeat (n) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk);
            #1;
            if (a0 && !sticky) req0_valid = 1'b0;
            if (a1 && !sticky) req1_valid = 1'b0;
        end
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req0_valid = 1'b1; req0_d1 = a; req0_d2 = b; req0_ctrl = c;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req1_valid = 1'b1; req1_d1 = a; req1_d2 = b; req1_ctrl = c;
    endtask

    // Stimulus
    initial begin : stimulus
        logic a0, a1;
        rst = 1'b1; sticky = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_d1 = 32'd0; req0_d2 = 32'd0; req0_ctrl = 3'b000;
        req1_valid = 1'b0; req1_d1 = 32'd0; req1_d2 = 32'd0; req1_ctrl = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step(1);

        resp_ready = 1'b1;
        drive0(32'd5, 32'd7, 3'b010);
        step(6);

        drive1(32'h1_0000, 32'h1_0000, 3'b111);
        step(9);

        sticky = 1'b1;
        drive0(32'd9, 32'd9, 3'b110);
        drive1(32'hF0, 32'h0F, 3'b001);
        step(14);
        sticky = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(4);

        resp_ready = 1'b0;
        sticky = 1'b1;
        drive0(32'd1, 32'd2, 3'b010);
        step(13);
        resp_ready = 1'b1;
        step(4);
        sticky = 1'b0;
        req0_valid = 1'b0;
        step(4);

        drive1(32'd6, 32'd7, 3'b111);
        step(2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(8);
        drive0(32'd3, 32'd3, 3'b000);
        drive1(32'd8, 32'd1, 3'b110);
        step(8);

        drive0(32'd3, 32'd4, 3'b011);
        step(5);

        repeat (3000) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_d1    = $urandom();
                req0_d2    = ($urandom_range(0, 3) == 0) ? req0_d1 : $urandom();
                req0_ctrl  = 3'($urandom_range(0, 7));
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_d1    = $urandom();
                req1_d2    = ($urandom_range(0, 3) == 0) ? req1_d1 : $urandom_range(0, 255);
                req1_ctrl  = 3'($urandom_range(0, 7));
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
